led_drv: RTL

- Output-side counterpart to the board push-button/switch input conditioning: drives one board LED from internal status and activity signals.
- Converts single-cycle activity events into visible, human-scale pulses. Provides static ON/OFF and blink modes.
- Timed by the shared slow tick strobe; one instance per LED in the board top, next to the button inputs.

---
 rtl/led_drv_pkg.sv | 21 ++
 rtl/led_drv_pwm.sv | 22 ++
 rtl/led_drv.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/led_drv_pkg.sv
// Board I/O package: LED mode encoding and activity-FSM states shared by the LED drivers.
package led_drv_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_ACT   = 2'd3
    } led_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } led_act_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_drv_pwm.sv
// Free-running 4-bit clk-rate PWM gate used to dim an LED when LED_DRV_DIM_EN is defined.
module led_pwm (
    input  logic       clk,
    input  logic       arst_n,
    input  logic [3:0] i_duty,
    output logic       o_on
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_cnt <= 4'd0;
        end else begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    // Full scale is special-cased so duty 15 is solid on rather than 15/16.
    assign o_on = (i_duty == 4'hF) | (r_cnt < i_duty);

endmodule

// File: rtl/led_drv.sv
// Single board LED driver: OFF / ON / BLINK / ACTIVITY-stretch modes timed by the 1 ms tick.
// Optional PWM dimming (extra duty input) is enabled by defining LED_DRV_DIM_EN.
module led_drv
    import led_drv_pkg::*;
#(
    parameter logic        ACTIVE           = 1'b1,
    parameter int unsigned STRETCH_TICKS    = 50,
    parameter int unsigned GAP_TICKS        = 50,
    parameter int unsigned BLINK_HALF_TICKS = 250
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       tick_ms,
    input  logic [1:0] mode,
    input  logic       evt,
`ifdef LED_DRV_DIM_EN
    input  logic [3:0] duty,
`endif
    output logic       led
);

    localparam int unsigned ACT_W = $clog2(max_u(STRETCH_TICKS, GAP_TICKS) + 1);
    localparam int unsigned BLK_W = $clog2(BLINK_HALF_TICKS + 1);

    localparam logic [ACT_W-1:0] STRETCH_LAST = ACT_W'(STRETCH_TICKS - 1);
    localparam logic [ACT_W-1:0] GAP_LAST     = ACT_W'(GAP_TICKS - 1);
    localparam logic [BLK_W-1:0] BLINK_LAST   = BLK_W'(BLINK_HALF_TICKS - 1);

    led_mode_t      w_mode;
    led_mode_t      r_mode;
    logic           r_evt;
    logic           w_evt_rise;
    logic           w_blink_entry;

    logic [BLK_W-1:0] r_blink_cnt;
    logic             r_phase;

    led_act_state_t   r_state;
    led_act_state_t   w_state_nxt;
    logic [ACT_W-1:0] r_act_cnt;
    logic [ACT_W-1:0] w_act_cnt_nxt;
    logic             r_pend;
    logic             w_pend_nxt;

    logic w_lit;
    logic w_lit_eff;
    logic r_led;

    assign w_mode        = led_mode_t'(mode);
    assign w_evt_rise    = evt & ~r_evt;
    assign w_blink_entry = (w_mode == LED_BLINK) && (r_mode != LED_BLINK);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_mode <= LED_OFF;
            r_evt  <= 1'b0;
        end else begin
            r_mode <= w_mode;
            r_evt  <= evt;
        end
    end

    // Blink counter is only touched in BLINK; it is re-armed on every entry.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (w_blink_entry) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if ((w_mode == LED_BLINK) && tick_ms) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_act_cnt_nxt = r_act_cnt;
        w_pend_nxt    = r_pend;
        if (w_mode != LED_ACT) begin
            w_state_nxt   = IDLE;
            w_act_cnt_nxt = '0;
            w_pend_nxt    = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // A tick arriving with the starting event is deliberately not counted.
                    if (w_evt_rise) begin
                        w_state_nxt   = SHOW;
                        w_act_cnt_nxt = '0;
                    end
                end
                SHOW: begin
                    if (w_evt_rise) begin
                        w_pend_nxt = 1'b1;
                    end
                    if (tick_ms) begin
                        if (r_act_cnt == STRETCH_LAST) begin
                            w_state_nxt   = GAP;
                            w_act_cnt_nxt = '0;
                        end else begin
                            w_act_cnt_nxt = r_act_cnt + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (tick_ms && (r_act_cnt == GAP_LAST)) begin
                        w_act_cnt_nxt = '0;
                        w_pend_nxt    = 1'b0;
                        w_state_nxt   = (r_pend || w_evt_rise) ? SHOW : IDLE;
                    end else begin
                        if (w_evt_rise) begin
                            w_pend_nxt = 1'b1;
                        end
                        if (tick_ms) begin
                            w_act_cnt_nxt = r_act_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt   = IDLE;
                    w_act_cnt_nxt = '0;
                    w_pend_nxt    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state   <= IDLE;
            r_act_cnt <= '0;
            r_pend    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_act_cnt <= w_act_cnt_nxt;
            r_pend    <= w_pend_nxt;
        end
    end

    always_comb begin
        w_lit = 1'b0;
        case (w_mode)
            LED_OFF:   w_lit = 1'b0;
            LED_ON:    w_lit = 1'b1;
            LED_BLINK: w_lit = w_blink_entry | r_phase;
            LED_ACT:   w_lit = (r_state == SHOW);
            default:   w_lit = 1'b0;
        endcase
    end

`ifdef LED_DRV_DIM_EN
    logic w_pwm_on;

    led_pwm u_pwm (
        .clk    (clk),
        .arst_n (arst_n),
        .i_duty (duty),
        .o_on   (w_pwm_on)
    );

    assign w_lit_eff = w_lit & w_pwm_on;
`else
    assign w_lit_eff = w_lit;
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_led <= ~ACTIVE;
        end else begin
            r_led <= w_lit_eff ? ACTIVE : ~ACTIVE;
        end
    end

    assign led = r_led;

endmodule
